pattern_prbs_tx: RTL and testbench
==================================

PATTERN_PRBS_TX -- requirements
Module: pattern_prbs_tx

Interface
REQ-001 The block SHALL have a single clock and a synchronous active-high reset, listed first: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL have the port pattern, input, 32 bits: the preamble word, sampled at start.
REQ-003 The block SHALL have the port n, input, 8 bits: the number of pattern repetitions, sampled at start.
REQ-004 The block SHALL have the port enable, input, 1 bit: advance one byte per cycle while high; hold while low.
REQ-005 The block SHALL have the port byte_out, output, 8 bits: the transmitted byte, registered.
REQ-006 The block SHALL have the port byte_valid, output, 1 bit: byte_out is a new byte this cycle, registered.
REQ-007 The block SHALL have the port pattern_done, output, 1 bit: level signal, high once all 4*n pattern bytes have been issued.

Function
REQ-008 The block SHALL implement the states IDLE, PATTERN and PRBS.
REQ-009 In IDLE with enable=1, the block SHALL capture pattern and n into internal registers, load the LFSR with seed 15'h7FFF, and leave IDLE on that same edge.
REQ-010 On that edge, if n!=0, the block SHALL enter PATTERN and drive byte_out=pattern[7:0] and byte_valid=1; if n=0, it SHALL enter PRBS, drive the first PRBS byte, and set pattern_done=1.
REQ-011 Latency SHALL be 1 cycle: enable high in cycle t produces a valid byte in cycle t+1.
REQ-012 In PATTERN, bytes SHALL be issued LSB-first: byte index 0..3 maps to pattern[7:0], [15:8], [23:16], [31:24].
REQ-013 The byte index SHALL be a 2-bit counter that wraps 3->0.
REQ-014 A repetition counter (8 bits) SHALL increment when the byte index wraps.
REQ-015 When the last byte of repetition n is issued, the next enabled edge SHALL enter PRBS, issue the first PRBS byte, and set pattern_done=1.
REQ-016 pattern_done SHALL stay high until rst.
REQ-017 The PRBS generator SHALL be a 15-bit Fibonacci LFSR, x^15+x^14+1.
REQ-018 Each LFSR step SHALL compute fb = lfsr[14]^lfsr[13] and then lfsr <= {lfsr[13:0], fb}.
REQ-019 Each PRBS byte SHALL consume exactly 8 steps in one cycle; byte bit k equals fb of step k (k=0 first).
REQ-020 PRBS SHALL continue indefinitely; it has no exit except rst.
REQ-021 With enable=0 in any state, byte_valid SHALL be 0 on the next edge.
REQ-022 With enable=0, byte_out, the counters, the LFSR and the state SHALL hold.
REQ-023 The sequence SHALL resume without skipping or repeating any byte when enable returns to 1.
REQ-024 Changes on pattern or n after leaving IDLE SHALL be ignored.
REQ-025 n=255 SHALL yield exactly 1020 pattern bytes, with no repetition-counter overflow before the transition.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL force state=IDLE, byte_out=8'h00, byte_valid=0, pattern_done=0, byte index=0, repetition count=0 and lfsr=15'h7FFF.
REQ-027 rst SHALL take priority over enable.
REQ-028 rst asserted mid-PATTERN or mid-PRBS SHALL abort immediately; the next start recaptures pattern and n.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, PATTERN, PRBS), the PRBS seed constant 15'h7FFF and the tap positions 14/13.
REQ-030 The package SHALL be the same one used by the receive-side detector, so both ends agree on seed and taps.
REQ-031 The LFSR SHALL be a separate sub-module, prbs15_byte_gen, with a load/advance/seed interface that produces 8 bits per advance.
REQ-032 The FSM and counters SHALL remain in pattern_prbs_tx.

Verification
REQ-033 The bench SHALL cover: rst, pattern=32'hA1B2C3D4, n=2, enable held high -> valid bytes D4,C3,B2,A1,D4,C3,B2,A1, then 00,40; pattern_done rises with the 00 byte.
REQ-034 The bench SHALL cover: n=0, enable high -> first valid byte 00, second 40, pattern_done=1 from the first valid byte.
REQ-035 The bench SHALL cover: n=1, enable dropped for 3 cycles after byte C3 -> byte_valid=0 for those 3 cycles, byte_out held at C3, then B2,A1,00 follow.
REQ-036 The bench SHALL cover: rst pulsed after the 5th byte of an n=3 run -> outputs return to reset values; restarting with pattern=32'h11223344, n=1 gives 44,33,22,11,00.
REQ-037 The bench SHALL cover: pattern changed to 32'hFFFFFFFF during PATTERN of an n=2 run with 32'h01020304 -> all 8 pattern bytes still come from 01020304.
REQ-038 The bench SHALL cover: n=255 -> exactly 1020 pattern bytes before the first 00 PRBS byte; then a 32767-byte-aligned check against a reference PRBS-15 model with no mismatch.

Source files
------------

// File: rtl/pattern_prbs_tx_pkg.sv
// Shared definitions for the pattern/PRBS-15 transmitter and its receive-side
// detector: state encoding, LFSR seed, tap positions and the 8-step helper.
package pattern_prbs_tx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PATTERN = 2'd1,
      PRBS    = 2'd2
   } tx_state_e;

   localparam logic [14:0] PRBS_SEED  = 15'h7FFF;
   localparam int unsigned PRBS_TAP_A = 14;
   localparam int unsigned PRBS_TAP_B = 13;

   typedef struct packed {
      logic [14:0] state;
      logic [7:0]  bits;
   } prbs_step_t;

   // Eight Fibonacci steps of x^15+x^14+1; bit k of the result is the
   // feedback produced by step k, so the first step lands in bit 0.
   function automatic prbs_step_t prbs15_step8(input logic [14:0] start);
      prbs_step_t  res;
      logic [14:0] lfsr;
      logic        fb;
      lfsr     = start;
      res.bits = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         fb          = lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B];
         res.bits[k] = fb;
         lfsr        = {lfsr[13:0], fb};
      end
      res.state = lfsr;
      return res;
   endfunction

endpackage

// File: rtl/pattern_prbs_tx_prbs15.sv
// PRBS-15 byte generator: 8 LFSR steps per advance. When load and advance are
// both high the byte is taken from the seed, so a start edge can emit data.
module prbs15_byte_gen
   import pattern_prbs_tx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   input  logic [14:0] seed,
   output logic [7:0]  bits_o
);

   logic [14:0] lfsr_q;
   logic [14:0] lfsr_d;
   logic [14:0] start_state;
   prbs_step_t  step;

   // Next byte from the effective starting state and the resulting LFSR update.
   always_comb begin
      start_state = load ? seed : lfsr_q;
      step        = prbs15_step8(start_state);
      bits_o      = step.bits;
      lfsr_d      = lfsr_q;
      if (advance) begin
         lfsr_d = step.state;
      end else if (load) begin
         lfsr_d = seed;
      end
   end

   // LFSR state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= PRBS_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/pattern_prbs_tx.sv
// Transmitter: n repetitions of a 32-bit preamble (LSB byte first), then an
// endless PRBS-15 byte stream. One byte per enabled cycle, everything holds
// while enable is low.
module pattern_prbs_tx
   import pattern_prbs_tx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pattern,
   input  logic [7:0]  n,
   input  logic        enable,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        pattern_done
);

   tx_state_e   state_q, state_d;
   logic [31:0] pattern_q, pattern_d;
   logic [7:0]  n_q, n_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  rep_q, rep_d;
   logic [7:0]  byte_q, byte_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;

   logic        gen_load;
   logic        gen_adv;
   logic [7:0]  gen_bits;
   logic [7:0]  pat_byte;

   prbs15_byte_gen u_prbs (
      .clk     (clk),
      .rst     (rst),
      .load    (gen_load),
      .advance (gen_adv),
      .seed    (PRBS_SEED),
      .bits_o  (gen_bits)
   );

   // Preamble byte selected by the index of the next byte to send.
   always_comb begin
      pat_byte = pattern_q[7:0];
      case (idx_q)
         2'd0:    pat_byte = pattern_q[7:0];
         2'd1:    pat_byte = pattern_q[15:8];
         2'd2:    pat_byte = pattern_q[23:16];
         default: pat_byte = pattern_q[31:24];
      endcase
   end

   // Next-state, counters and output byte.
   // idx_q is the index of the next preamble byte and rep_q counts completed
   // repetitions; the start edge already issues byte 0, so PATTERN begins at
   // index 1 and the exit test rep_q == n_q never needs a ninth counter bit.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      n_d       = n_q;
      idx_d     = idx_q;
      rep_d     = rep_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      done_d    = done_q;
      gen_load  = 1'b0;
      gen_adv   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               pattern_d = pattern;
               n_d       = n;
               gen_load  = 1'b1;
               rep_d     = '0;
               valid_d   = 1'b1;
               if (n != 8'd0) begin
                  state_d = PATTERN;
                  byte_d  = pattern[7:0];
                  idx_d   = 2'd1;
               end else begin
                  state_d = PRBS;
                  gen_adv = 1'b1;
                  byte_d  = gen_bits;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end
            end
         end
         PATTERN: begin
            if (enable) begin
               valid_d = 1'b1;
               if (rep_q == n_q) begin
                  state_d = PRBS;
                  gen_adv = 1'b1;
                  byte_d  = gen_bits;
                  done_d  = 1'b1;
               end else begin
                  byte_d = pat_byte;
                  idx_d  = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     rep_d = rep_q + 8'd1;
                  end
               end
            end
         end
         PRBS: begin
            if (enable) begin
               gen_adv = 1'b1;
               byte_d  = gen_bits;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         rep_q     <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         rep_q     <= rep_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   assign byte_out     = byte_q;
   assign byte_valid   = valid_q;
   assign pattern_done = done_q;

endmodule

// File: tb/tb_pattern_prbs_tx.sv
// Bench for pattern_prbs_tx: stream-level reference model checked every
// cycle, directed scenarios with literal byte sequences, random stimulus.
module tb_pattern_prbs_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pattern;
   logic [7:0]  n;
   logic        enable;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        pattern_done;

   int vectors = 0;
   int fails   = 0;
   bit chk_en  = 1'b0;

   pattern_prbs_tx dut (
      .clk          (clk),
      .rst          (rst),
      .pattern      (pattern),
      .n            (n),
      .enable       (enable),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .pattern_done (pattern_done)
   );

   always #5 clk = ~clk;

   // One period of the PRBS-15 output bitstream from the recurrence
   // x[i+15] = x[i] ^ x[i+1], history seeded with all ones.
   bit prbs_ref [0:32766];
   bit xs [0:32781];

   function automatic bit [7:0] prbs_byte(input int unsigned j);
      bit [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = prbs_ref[(8 * j + k) % 32767];
      return b;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Reference model: the transmitted stream is 4*n preamble bytes followed by
   // PRBS bytes; each enabled cycle emits stream element m_idx.
   bit          m_started;
   int unsigned m_idx;
   bit [31:0]   m_pat;
   int unsigned m_n;
   bit [7:0]    m_byte;
   bit          m_valid;
   bit          m_done;

   always @(posedge clk) begin
      if (rst) begin
         m_started = 0; m_idx = 0; m_byte = 0; m_valid = 0; m_done = 0;
      end else if (enable) begin
         if (!m_started) begin
            m_started = 1; m_pat = pattern; m_n = n; m_idx = 0;
         end
         if (m_idx < 4 * m_n) begin
            m_byte = m_pat[8 * (m_idx % 4) +: 8];
         end else begin
            m_byte = prbs_byte(m_idx - 4 * m_n);
            m_done = 1;
         end
         m_valid = 1;
         m_idx++;
      end else begin
         m_valid = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_valid", byte_valid, m_valid);
         check("model_done", pattern_done, m_done);
         check("model_byte", byte_out, m_byte);
      end
   end

   bit       cap_on = 0;
   bit [7:0] cap_b[$];
   bit       cap_d[$];
   bit [7:0] exp_q[$];

   always @(negedge clk) begin
      if (cap_on && byte_valid === 1'b1) begin
         cap_b.push_back(byte_out);
         cap_d.push_back(pattern_done);
      end
   end

   task automatic check_cap(input string nm);
      check({nm, "_len"}, cap_b.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_b.size(); i++)
         check($sformatf("%s[%0d]", nm, i), cap_b[i], exp_q[i]);
   endtask

   task automatic do_reset();
      rst = 1; enable = 0;
      @(negedge clk);
      rst = 0;
      cap_b.delete(); cap_d.delete();
   endtask

   task automatic run_en(input int cycles);
      enable = 1;
      repeat (cycles) @(negedge clk);
      enable = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ones;
      int cnt;
      bit found;
      for (int i = 0; i < 15; i++) xs[i] = 1;
      for (int j = 0; j < 32767; j++) begin
         xs[15 + j]  = xs[j] ^ xs[j + 1];
         prbs_ref[j] = xs[15 + j];
      end
      // Hand-derived anchors for the model itself.
      check("model_prbs_b0", prbs_byte(0), 8'h00);
      check("model_prbs_b1", prbs_byte(1), 8'h40);
      check("model_prbs_b2", prbs_byte(2), 8'h00);
      check("model_prbs_b3", prbs_byte(3), 8'h30);
      ones = 0;
      for (int j = 0; j < 32767; j++) ones += prbs_ref[j];
      check("model_prbs_ones", ones, 16384);

      rst = 1; enable = 0; pattern = '0; n = '0;
      @(negedge clk);
      chk_en = 1;
      check("rst_byte", byte_out, 8'h00);
      check("rst_valid", byte_valid, 1'b0);
      check("rst_done", pattern_done, 1'b0);
      rst = 0;
      cap_on = 1;

      // n=2 preamble then PRBS
      do_reset();
      pattern = 32'hA1B2C3D4; n = 8'd2;
      run_en(10);
      repeat (2) @(negedge clk);
      exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h40};
      check_cap("n2_seq");
      if (cap_d.size() >= 9) begin
         check("n2_done_before", cap_d[7], 1'b0);
         check("n2_done_rise", cap_d[8], 1'b1);
      end

      // n=0 goes straight to PRBS
      do_reset();
      pattern = 32'h12345678; n = 8'd0;
      run_en(2);
      @(negedge clk);
      exp_q = '{8'h00, 8'h40};
      check_cap("n0_seq");
      if (cap_d.size() >= 1) check("n0_done_first", cap_d[0], 1'b1);

      // n=1 with a 3-cycle enable gap after C3
      do_reset();
      pattern = 32'hA1B2C3D4; n = 8'd1;
      run_en(2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("gap_valid", byte_valid, 1'b0);
         check("gap_byte", byte_out, 8'hC3);
      end
      run_en(3);
      @(negedge clk);
      exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00};
      check_cap("gap_seq");

      // reset mid-run (enable held high through reset), then restart
      do_reset();
      pattern = 32'h55667788; n = 8'd3;
      enable = 1;
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("abort_byte", byte_out, 8'h00);
      check("abort_valid", byte_valid, 1'b0);
      check("abort_done", pattern_done, 1'b0);
      rst = 0; enable = 0;
      cap_b.delete(); cap_d.delete();
      pattern = 32'h11223344; n = 8'd1;
      run_en(5);
      @(negedge clk);
      exp_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
      check_cap("restart_seq");

      // inputs changed after start are ignored
      do_reset();
      pattern = 32'h01020304; n = 8'd2;
      enable = 1;
      @(negedge clk);
      pattern = 32'hFFFFFFFF; n = 8'd0;
      repeat (8) @(negedge clk);
      enable = 0;
      @(negedge clk);
      exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
      check_cap("ignore_seq");

      // n=255: 1020 preamble bytes, then a long PRBS run
      cap_on = 0;
      do_reset();
      pattern = $urandom; n = 8'd255;
      enable = 1;
      cnt = 0; found = 0;
      for (int c = 0; c < 1100 && !found; c++) begin
         @(negedge clk);
         if (byte_valid === 1'b1 && pattern_done === 1'b0) cnt++;
         if (pattern_done === 1'b1) begin
            found = 1;
            check("n255_first_prbs", byte_out, 8'h00);
         end
      end
      check("n255_done_seen", found, 1'b1);
      check("n255_count", cnt, 1020);
      repeat (32766) @(negedge clk);
      enable = 0;
      @(negedge clk);

      // randomized runs with enable gaps, late input changes and stray resets
      for (int r = 0; r < 40; r++) begin
         do_reset();
         pattern = $urandom;
         n = 8'($urandom_range(0, 6));
         for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) pattern = $urandom;
            if ($urandom_range(0, 7) == 0) n = 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 49) == 0);
            @(negedge clk);
         end
         rst = 0;
      end

      enable = 0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
